// File: rtl/gates7_pkg.sv
// Shared definitions for the seven-gate block and its response checker:
// output bit positions, vector width and checker FSM states.
package gates7_pkg;

   localparam int unsigned GATES7_W = 7;

   localparam int unsigned F_AND  = 6;
   localparam int unsigned F_OR   = 5;
   localparam int unsigned F_NOT  = 4;
   localparam int unsigned F_NAND = 3;
   localparam int unsigned F_NOR  = 2;
   localparam int unsigned F_XOR  = 1;
   localparam int unsigned F_XNOR = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gates7_golden.sv
// Combinational golden model of the seven-gate block; produces the
// expected packed output vector for inputs a and b.
module gates7_golden
   import gates7_pkg::*;
(
   input  logic                a,
   input  logic                b,
   output logic [GATES7_W-1:0] expected
);

   always_comb begin
      expected         = '0;
      expected[F_AND]  = a & b;
      expected[F_OR]   = a | b;
      expected[F_NOT]  = ~a;
      expected[F_NAND] = ~(a & b);
      expected[F_NOR]  = ~(a | b);
      expected[F_XOR]  = a ^ b;
      expected[F_XNOR] = ~(a ^ b);
   end

endmodule

// File: rtl/gates7_checker.sv
// Self-checking response monitor: compares each accepted beat against the
// golden model, counts mismatches, tracks input coverage, reports pass/fail.
module gates7_checker
   import gates7_pkg::*;
#(
   parameter int unsigned NUM_VECTORS = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   input  logic                a,
   input  logic                b,
   input  logic [GATES7_W-1:0] f,
   output logic                in_ready,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                err_pulse,
   output logic [CNT_W-1:0]    err_count,
   output logic [CNT_W-1:0]    first_err_idx,
   output logic [GATES7_W-1:0] first_err_mask,
   output logic [3:0]          coverage
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam bit               SHORT_RUN = (NUM_VECTORS < 4);

   state_t              state, state_nx;
   logic [CNT_W-1:0]    vec_idx;
   logic                err_seen;
   logic                accept;
   logic [GATES7_W-1:0] expected;
   logic [GATES7_W-1:0] mismatch;

   gates7_golden u_golden (
      .a        (a),
      .b        (b),
      .expected (expected)
   );

   always_comb begin
      mismatch = expected ^ f;
   end

   // start takes priority over a beat in RUN, so that beat is discarded
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (!start && in_valid) begin
               accept = 1'b1;
               if (vec_idx == LAST_IDX) state_nx = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nx = RUN;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      pass = done && (err_count == '0) && ((coverage == 4'b1111) || SHORT_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         vec_idx        <= '0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_mask <= '0;
         coverage       <= '0;
         err_seen       <= 1'b0;
         err_pulse      <= 1'b0;
      end else begin
         state     <= state_nx;
         err_pulse <= 1'b0;
         if (start) begin
            vec_idx        <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_mask <= '0;
            coverage       <= '0;
            err_seen       <= 1'b0;
         end else if (accept) begin
            coverage[{a, b}] <= 1'b1;
            vec_idx          <= vec_idx + 1'b1;
            if (mismatch != '0) begin
               err_pulse <= 1'b1;
               if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
               if (!err_seen) begin
                  err_seen       <= 1'b1;
                  first_err_idx  <= vec_idx;
                  first_err_mask <= mismatch;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gates7_checker.sv
// Directed plus randomized bench for gates7_checker against a run-level
// reference model; a second instance covers the narrow-counter build.
module tb_gates7_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, in_valid, a, b;
   logic [6:0] f;
   logic       in_ready, busy, done, pass, err_pulse;
   logic [7:0] err_count, first_err_idx;
   logic [6:0] first_err_mask;
   logic [3:0] coverage;

   logic       s_start, s_in_valid, s_a, s_b;
   logic [6:0] s_f;
   logic       s_in_ready, s_busy, s_done, s_pass, s_err_pulse;
   logic [1:0] s_err_count, s_first_err_idx;
   logic [6:0] s_first_err_mask;
   logic [3:0] s_coverage;

   gates7_checker #(.NUM_VECTORS(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b), .f(f),
      .in_ready(in_ready), .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
      .err_count(err_count), .first_err_idx(first_err_idx),
      .first_err_mask(first_err_mask), .coverage(coverage)
   );

   gates7_checker #(.NUM_VECTORS(3), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .a(s_a), .b(s_b), .f(s_f),
      .in_ready(s_in_ready), .busy(s_busy), .done(s_done), .pass(s_pass), .err_pulse(s_err_pulse),
      .err_count(s_err_count), .first_err_idx(s_first_err_idx),
      .first_err_mask(s_first_err_mask), .coverage(s_coverage)
   );

   int checks = 0;
   int errors = 0;

   // reference model of one run of the 4-beat instance
   bit         m_run, m_done, m_seen, m_pulse;
   int         m_idx, m_cnt, m_first_idx;
   logic [6:0] m_first_mask;
   logic [3:0] m_cov;

   function automatic logic [6:0] ref_f(logic ai, logic bi);
      int s;
      s = int'(ai) + int'(bi);
      return {s == 2, s >= 1, ai == 1'b0, s != 2, s == 0, s == 1, s != 1};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_idx = 0; m_cnt = 0; m_first_idx = 0; m_first_mask = '0;
      m_cov = '0; m_seen = 0; m_pulse = 0;
   endtask

   task automatic check_all(string tag);
      chk({tag, ".err_pulse"}, err_pulse, m_pulse);
      chk({tag, ".err_count"}, err_count, m_cnt);
      chk({tag, ".coverage"}, coverage, m_cov);
      chk({tag, ".first_idx"}, first_err_idx, m_first_idx);
      chk({tag, ".first_mask"}, first_err_mask, m_first_mask);
      chk({tag, ".done"}, done, m_done);
      chk({tag, ".busy"}, busy, m_run);
      chk({tag, ".pass"}, pass, m_done && m_cnt == 0 && m_cov == 4'hF);
   endtask

   task automatic do_start(logic vin, logic [6:0] fin);
      start = 1'b1; in_valid = vin; a = 1'b1; b = 1'b0; f = fin;
      tick();
      start = 1'b0; in_valid = 1'b0;
      m_run = 1; m_done = 0;
      model_clear();
      check_all("start");
      chk("start.in_ready", in_ready, 1);
   endtask

   task automatic beat(logic ai, logic bi, logic [6:0] fi);
      logic [6:0] mm;
      a = ai; b = bi; f = fi; in_valid = 1'b1;
      tick();
      m_pulse = 0;
      if (m_run) begin
         mm = ref_f(ai, bi) ^ fi;
         m_cov[{ai, bi}] = 1'b1;
         if (mm != 0) begin
            m_pulse = 1;
            if (m_cnt < 255) m_cnt++;
            if (!m_seen) begin
               m_seen = 1; m_first_idx = m_idx; m_first_mask = mm;
            end
         end
         m_idx++;
         if (m_idx == 4) begin
            m_run = 0; m_done = 1;
         end
      end
      check_all("beat");
   endtask

   task automatic gap(int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         m_pulse = 0;
         check_all("gap");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] flip;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; f = '0;
      s_start = 1'b0; s_in_valid = 1'b0; s_a = 1'b0; s_b = 1'b0; s_f = '0;
      m_run = 0; m_done = 0;
      model_clear();
      tick(); tick();
      check_all("reset");
      chk("reset.in_ready", in_ready, 0);
      chk("reset.s_err_count", s_err_count, 0);
      chk("reset.s_done", s_done, 0);
      rst = 1'b0;

      // in_valid ignored in IDLE
      in_valid = 1'b1; f = 7'h7F;
      tick();
      check_all("idle_ignore");
      in_valid = 1'b0;

      // all four combinations correct
      do_start(1'b0, '0);
      beat(0, 0, ref_f(0, 0));
      beat(0, 1, ref_f(0, 1));
      beat(1, 0, ref_f(1, 0));
      beat(1, 1, ref_f(1, 1));
      chk("clean.pass", pass, 1);
      chk("clean.coverage", coverage, 4'b1111);
      // in_valid ignored in DONE
      beat(1, 1, 7'h55);
      chk("done_hold.done", done, 1);
      in_valid = 1'b0;

      // beat 2 with xor bit flipped
      do_start(1'b0, '0);
      beat(0, 0, ref_f(0, 0));
      beat(0, 1, ref_f(0, 1));
      beat(1, 0, ref_f(1, 0) ^ 7'b0000010);
      chk("flip.err_pulse", err_pulse, 1);
      beat(1, 1, ref_f(1, 1));
      chk("flip.first_idx", first_err_idx, 2);
      chk("flip.first_mask", first_err_mask, 7'b0000010);
      chk("flip.pass", pass, 0);

      // gap of three idle cycles between beats 1 and 2
      do_start(1'b0, '0);
      beat(0, 0, ref_f(0, 0));
      beat(0, 1, ref_f(0, 1));
      gap(3);
      beat(1, 0, ref_f(1, 0));
      chk("gap.not_done", done, 0);
      beat(1, 1, ref_f(1, 1));
      chk("gap.done", done, 1);

      // incomplete coverage fails even with no errors
      do_start(1'b0, '0);
      for (int i = 0; i < 4; i++) beat(0, 0, ref_f(0, 0));
      chk("cov.coverage", coverage, 4'b0001);
      chk("cov.pass", pass, 0);

      // restart mid-run; the beat coincident with start is discarded
      do_start(1'b0, '0);
      beat(1, 1, 7'h00);
      beat(0, 1, ref_f(0, 1));
      do_start(1'b1, 7'h00);
      for (int i = 0; i < 3; i++) beat(i[1], i[0], ref_f(i[1], i[0]));
      chk("restart.not_done", done, 0);
      beat(1, 1, ref_f(1, 1));
      chk("restart.pass", pass, 1);

      // reset mid-run
      do_start(1'b0, '0);
      beat(1, 1, 7'h00);
      beat(0, 0, ref_f(0, 0));
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      m_run = 0; m_done = 0;
      model_clear();
      check_all("rst_mid");
      chk("rst_mid.in_ready", in_ready, 0);
      in_valid = 1'b1; f = 7'h00;
      tick();
      check_all("rst_after");
      chk("rst_after.in_ready", in_ready, 0);
      in_valid = 1'b0;

      // randomized runs
      for (int r = 0; r < 8; r++) begin
         do_start(1'b0, '0);
         for (int k = 0; k < 4; k++) begin
            logic ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            flip = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'h00;
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
            beat(ra, rb, ref_f(ra, rb) ^ flip);
         end
         in_valid = 1'b0;
      end

      // narrow counter instance: three wrong beats saturate at 3
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      chk("sat.busy", s_busy, 1);
      for (int i = 0; i < 3; i++) begin
         s_a = i[0]; s_b = 1'b1; s_f = ~ref_f(i[0], 1'b1); s_in_valid = 1'b1;
         tick();
         chk("sat.err_count", s_err_count, i + 1);
         chk("sat.err_pulse", s_err_pulse, 1);
      end
      s_in_valid = 1'b0;
      chk("sat.done", s_done, 1);
      chk("sat.pass", s_pass, 0);
      chk("sat.first_idx", s_first_err_idx, 0);
      chk("sat.first_mask", s_first_err_mask, 7'h7F);
      tick();
      chk("sat.hold", s_err_count, 3);

      // short run passes without full coverage when error-free
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      chk("short.cleared", s_err_count, 0);
      for (int i = 0; i < 3; i++) begin
         s_a = 1'b0; s_b = i[0]; s_f = ref_f(1'b0, i[0]); s_in_valid = 1'b1;
         tick();
      end
      s_in_valid = 1'b0;
      chk("short.done", s_done, 1);
      chk("short.coverage", s_coverage, 4'b0011);
      chk("short.pass", s_pass, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
